xor_trigger: RTL and testbench
==============================

XOR_TRIGGER -- requirements
Module: xor_trigger

Interface
REQ-001 Parameter SYNC_STAGES, default 0, SHALL set the number of input synchronizer flops before edge detection; legal values are 0..3.
REQ-002 Parameter CNT_W, default 16, SHALL set the width of the edge counter; legal values are 4..32.
REQ-003 The block SHALL use one clock and a synchronous, active-high reset, with ports named clk and rstn.
REQ-004 Port clk, input, 1 bit: the clock; all state updates on its rising edge.
REQ-005 Port rstn, input, 1 bit: synchronous reset; a 1 sampled at a rising edge resets the block.
REQ-006 Port in, input, 1 bit: the monitored level signal.
REQ-007 Port out, output, 1 bit: registered one-cycle pulse on any change of the sampled input.
REQ-008 Port rise, output, 1 bit: registered one-cycle pulse on a 0->1 change of the sampled input.
REQ-009 Port fall, output, 1 bit: registered one-cycle pulse on a 1->0 change of the sampled input.
REQ-010 Port edge_cnt, output, CNT_W bits: count of detected changes; present only when XOR_TRIGGER_CNT_EN is defined.

Function
REQ-011 The sampled input s SHALL be in itself when SYNC_STAGES=0, else the output of a SYNC_STAGES-deep flop chain clocked by clk.
REQ-012 A register prev SHALL load s on every rising edge.
REQ-013 At every non-reset rising edge, out SHALL load (s XOR prev), rise SHALL load (s AND NOT prev), and fall SHALL load (NOT s AND prev).
REQ-014 Latency from the first rising edge at which s differs from prev to out=1 SHALL be zero edges after that edge; out is valid for exactly one clock period.
REQ-015 A level held for N cycles SHALL produce exactly one out pulse; a change every cycle SHALL hold out at 1 continuously.
REQ-016 rise and fall SHALL never be 1 simultaneously, and out SHALL equal (rise OR fall) at all times.
REQ-017 Outputs SHALL be driven only from flops; there is no combinational path from in to any output.

Reset
REQ-018 While rstn=1 at a rising edge, out, rise, fall and (if present) edge_cnt SHALL be cleared to 0.
REQ-019 During reset, prev and all synchronizer flops SHALL load the current input instead of clearing, so no pulse is emitted on reset release for a steady input.
REQ-020 Reset asserted mid-pulse SHALL clear the pulse at that edge.
REQ-021 Reset SHALL take priority over all other updates.

Configuration
REQ-022 When XOR_TRIGGER_CNT_EN is defined, edge_cnt SHALL increment by 1 at each edge where out loads 1, and SHALL saturate at all-ones with no wrap.
REQ-023 When XOR_TRIGGER_CNT_EN is undefined, the edge_cnt port and its counter logic SHALL be absent; all other behaviour is unchanged.

Structure
REQ-024 Package xor_trigger_pkg SHALL hold the SYNC_STAGES maximum (3), the default CNT_W (16), and the counter saturation constant function.
REQ-025 The input synchronizer SHALL be a sub-module, xor_trigger_sync, parameterized by depth, with its own reset-load-input behaviour per REQ-019.

Verification
REQ-026 Hold in=0, pulse rstn=1 for 3 cycles, then release -> out, rise and fall stay 0 and edge_cnt=0.
REQ-027 With SYNC_STAGES=0, drive in 0->1 between edges -> out=1 and rise=1 for exactly one cycle after the next edge; fall=0.
REQ-028 Drive in 1->0, then 0->1, each change held for 2 cycles -> two out pulses, the first with fall=1 and the second with rise=1; edge_cnt=2.
REQ-029 Hold in=1 through reset, then release reset -> no pulse after release.
REQ-030 Toggle in every cycle for 10 cycles -> out stays 1 for 10 cycles; with SYNC_STAGES=2 the same waveform appears 2 cycles later.
REQ-031 With CNT_W=4, apply 20 toggles -> edge_cnt saturates at 15; asserting rstn=1 then clears it to 0.

Source files
------------

// File: rtl/xor_trigger_pkg.sv
// Shared constants, edge-flag record and counter saturation helper for xor_trigger.
// The optional edge counter in the top is enabled with XOR_TRIGGER_CNT_EN.
package xor_trigger_pkg;

    localparam int SYNC_STAGES_MAX = 3;
    localparam int CNT_W_DEFAULT   = 16;

    typedef struct packed {
        logic any;
        logic rise;
        logic fall;
    } edge_flags_t;

    // All-ones value of a counter `width` bits wide (width is 1..32).
    function automatic logic [31:0] cnt_sat_value(input int width);
        cnt_sat_value = 32'hFFFF_FFFF >> (32 - width);
    endfunction

endpackage

// File: rtl/xor_trigger_sync.sv
// Input synchronizer chain of DEPTH flops (DEPTH = 0 is a plain wire).
// While reset is high every stage loads the live input so release is pulse-free.
module xor_trigger_sync #(
    parameter int DEPTH = 0
) (
    input  logic clk,
    input  logic rstn,
    input  logic i_d,
    output logic o_q
);

    localparam int LEN = (DEPTH == 0) ? 1 : DEPTH;

    logic [LEN-1:0] r_chain;

    always_ff @(posedge clk) begin
        if (rstn) begin
            r_chain <= {LEN{i_d}};
        end else begin
            r_chain[0] <= i_d;
            for (int k = 1; k < LEN; k++) begin
                r_chain[k] <= r_chain[k-1];
            end
        end
    end

    // With DEPTH = 0 the chain has no reader left after folding and is trimmed.
    assign o_q = (DEPTH == 0) ? i_d : r_chain[LEN-1];

endmodule

// File: rtl/xor_trigger.sv
// Registered change / rise / fall pulse generator on an optionally synchronized input.
// Define XOR_TRIGGER_CNT_EN to add the saturating edge_cnt output.
module xor_trigger
    import xor_trigger_pkg::*;
#(
    parameter int SYNC_STAGES = 0,
    parameter int CNT_W       = CNT_W_DEFAULT
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             in,
    output logic             out,
    output logic             rise,
    output logic             fall
`ifdef XOR_TRIGGER_CNT_EN
    ,
    output logic [CNT_W-1:0] edge_cnt
`endif
);

    logic        w_s;
    logic        w_change;
    logic        r_prev;
    edge_flags_t r_flags;

    xor_trigger_sync #(
        .DEPTH (SYNC_STAGES)
    ) u_sync (
        .clk  (clk),
        .rstn (rstn),
        .i_d  (in),
        .o_q  (w_s)
    );

    assign w_change = w_s ^ r_prev;

    // prev tracks the raw input during reset so a steady level never looks like a change.
    always_ff @(posedge clk) begin
        if (rstn) begin
            r_prev  <= in;
            r_flags <= '0;
        end else begin
            r_prev       <= w_s;
            r_flags.any  <= w_change;
            r_flags.rise <= w_s & ~r_prev;
            r_flags.fall <= ~w_s & r_prev;
        end
    end

    assign out  = r_flags.any;
    assign rise = r_flags.rise;
    assign fall = r_flags.fall;

`ifdef XOR_TRIGGER_CNT_EN
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(cnt_sat_value(CNT_W));

    logic [CNT_W-1:0] r_cnt;

    // Counts on the same edge that raises out, and sticks at all-ones.
    always_ff @(posedge clk) begin
        if (rstn) begin
            r_cnt <= '0;
        end else if (w_change && (r_cnt != CNT_MAX)) begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    assign edge_cnt = r_cnt;
`endif

endmodule

// File: tb/tb_xor_trigger.sv
// Self-checking bench for xor_trigger: a direct instance and a 2-stage synchronized instance
// compared against a delay-line history model; edge counters checked when XOR_TRIGGER_CNT_EN is set.
`timescale 1ns/1ps
module tb_xor_trigger;

    localparam int S_A   = 0;
    localparam int CNT_A = 4;
    localparam int S_B   = 2;
    localparam int CNT_B = 16;

    logic clk = 1'b0;
    logic rstn;
    logic in;
    logic outA, riseA, fallA;
    logic outB, riseB, fallB;
`ifdef XOR_TRIGGER_CNT_EN
    logic [CNT_A-1:0] cntA;
    logic [CNT_B-1:0] cntB;
`endif

    int checks = 0;
    int errors = 0;

    // Model: history of input samples taken at each rising edge.
    logic hist[$];
    logic expOutA, expRiseA, expFallA;
    logic expOutB, expRiseB, expFallB;
    int   expCntA, expCntB;

    always #5 clk = ~clk;

    xor_trigger #(.SYNC_STAGES(S_A), .CNT_W(CNT_A)) dutA (
        .clk  (clk),
        .rstn (rstn),
        .in   (in),
        .out  (outA),
        .rise (riseA),
        .fall (fallA)
`ifdef XOR_TRIGGER_CNT_EN
        ,
        .edge_cnt (cntA)
`endif
    );

    xor_trigger #(.SYNC_STAGES(S_B), .CNT_W(CNT_B)) dutB (
        .clk  (clk),
        .rstn (rstn),
        .in   (in),
        .out  (outB),
        .rise (riseB),
        .fall (fallB)
`ifdef XOR_TRIGGER_CNT_EN
        ,
        .edge_cnt (cntB)
`endif
    );

    task automatic checkOne(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Sampled value seen `delay` edges ago compared with the one before it.
    task automatic modelEdge(input logic inV, input logic rstV);
        int n;
        logic nowA, oldA, nowB, oldB;
        if (rstV) begin
            hist.delete();
            repeat (4) hist.push_back(inV);
            {expOutA, expRiseA, expFallA} = 3'b000;
            {expOutB, expRiseB, expFallB} = 3'b000;
            expCntA = 0;
            expCntB = 0;
        end else begin
            hist.push_back(inV);
            if (hist.size() > 8) void'(hist.pop_front());
            n    = hist.size();
            nowA = hist[n-1-S_A];
            oldA = hist[n-2-S_A];
            nowB = hist[n-1-S_B];
            oldB = hist[n-2-S_B];
            expOutA  = nowA != oldA;
            expRiseA = nowA && !oldA;
            expFallA = !nowA && oldA;
            expOutB  = nowB != oldB;
            expRiseB = nowB && !oldB;
            expFallB = !nowB && oldB;
            if (expOutA && expCntA < (2**CNT_A - 1)) expCntA++;
            if (expOutB && expCntB < (2**CNT_B - 1)) expCntB++;
        end
    endtask

    task automatic checkOutput(input string tag);
        checkOne({tag, ".outA"},  outA,  expOutA);
        checkOne({tag, ".riseA"}, riseA, expRiseA);
        checkOne({tag, ".fallA"}, fallA, expFallA);
        checkOne({tag, ".outB"},  outB,  expOutB);
        checkOne({tag, ".riseB"}, riseB, expRiseB);
        checkOne({tag, ".fallB"}, fallB, expFallB);
`ifdef XOR_TRIGGER_CNT_EN
        checkOne({tag, ".cntA"}, cntA, expCntA);
        checkOne({tag, ".cntB"}, cntB, expCntB);
`endif
    endtask

    // Drive between edges, let the model see the same edge, check just after it.
    task automatic applyStimulus(input string tag, input logic inV, input logic rstV);
        @(negedge clk);
        in   = inV;
        rstn = rstV;
        @(posedge clk);
        modelEdge(inV, rstV);
        #1;
        checkOutput(tag);
    endtask

    initial begin
        logic v;
        in   = 1'b0;
        rstn = 1'b1;

        // Reset with a steady low input, then release.
        repeat (3) applyStimulus("rst_low", 1'b0, 1'b1);
        repeat (3) applyStimulus("rel_low", 1'b0, 1'b0);
        checkOne("rel_low.outA_zero", outA, 1'b0);
        checkOne("rel_low.outB_zero", outB, 1'b0);

        // Single rise: direct instance pulses after one edge, synchronized two edges later.
        applyStimulus("rise1", 1'b1, 1'b0);
        checkOne("rise1.outA_one", outA, 1'b1);
        checkOne("rise1.riseA_one", riseA, 1'b1);
        checkOne("rise1.fallA_zero", fallA, 1'b0);
        applyStimulus("rise2", 1'b1, 1'b0);
        checkOne("rise2.outA_zero", outA, 1'b0);
        applyStimulus("rise3", 1'b1, 1'b0);
        checkOne("rise3.outB_one", outB, 1'b1);
        applyStimulus("rise4", 1'b1, 1'b0);

        // High through reset, no pulse on release; then fall and rise held 2 cycles each.
        repeat (2) applyStimulus("rst_high", 1'b1, 1'b1);
        repeat (3) applyStimulus("rel_high", 1'b1, 1'b0);
        checkOne("rel_high.outB_zero", outB, 1'b0);
        applyStimulus("fall_a", 1'b0, 1'b0);
        checkOne("fall_a.fallA_one", fallA, 1'b1);
        applyStimulus("fall_b", 1'b0, 1'b0);
        applyStimulus("rise_a", 1'b1, 1'b0);
        checkOne("rise_a.riseA_one", riseA, 1'b1);
        applyStimulus("rise_b", 1'b1, 1'b0);
`ifdef XOR_TRIGGER_CNT_EN
        checkOne("two_edges.cntA", cntA, 2);
`endif
        repeat (3) applyStimulus("settle", 1'b1, 1'b0);
`ifdef XOR_TRIGGER_CNT_EN
        checkOne("two_edges.cntB", cntB, 2);
`endif

        // Toggle every cycle: out held high continuously.
        v = 1'b1;
        for (int i = 0; i < 10; i++) begin
            v = ~v;
            applyStimulus("toggle", v, 1'b0);
            checkOne("toggle.outA_one", outA, 1'b1);
        end
        repeat (3) applyStimulus("toggle_tail", v, 1'b0);

        // Reset landing on a change edge clears the pulse there.
        applyStimulus("mid_rst", ~v, 1'b1);
        checkOne("mid_rst.outA_zero", outA, 1'b0);
        applyStimulus("mid_rel", ~v, 1'b0);

        // Saturation of the narrow counter, then reset clears it.
        v = ~v;
        for (int i = 0; i < 20; i++) begin
            v = ~v;
            applyStimulus("sat", v, 1'b0);
        end
`ifdef XOR_TRIGGER_CNT_EN
        checkOne("sat.cntA_max", cntA, 15);
`endif
        applyStimulus("sat_rst", v, 1'b1);
`ifdef XOR_TRIGGER_CNT_EN
        checkOne("sat_rst.cntA_zero", cntA, 0);
`endif

        // Random levels with occasional reset.
        for (int i = 0; i < 400; i++) begin
            applyStimulus("rand", 1'($urandom_range(0, 1)), ($urandom_range(0, 15) == 0));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
